// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//
// Pipeline sequencer for the 16-bit 5-stage core. It generates the load
// enables and bubble (flush) controls for the PC, IF/ID, ID/EX, EX/MEM and
// MEM/WB registers. It handles data-memory stalls, taken redirects resolved
// in MEM, halt drain, load-use hazards and instruction-memory stalls.
// All stage controls are combinational from FSM state and this cycle's inputs.
//
// Parameters:
//   LU_BUBBLES  bubbles inserted on a load-use hazard (legal 1..3)
//
// Ports:
//   clk, rst                 core clock; asynchronous active-low reset
//   id_rs, id_rt             source registers of the ID instruction
//   id_rs_used, id_rt_used   ID instruction actually reads that source
//   ex_write_reg             destination of the EX instruction
//   ex_RegWrt, ex_MemRead    EX instruction writes a register / is a load
//   redirect_mem             taken branch or jump in MEM
//   halt_mem                 valid HALT in MEM
//   imem_stall, dmem_stall   instruction / data memory not ready
//   *_en                     stage register load enables
//   *_flush                  stage register loads a bubble instead of d
//   halted                   registered; core has stopped
//   stall_cycles             perf counter: cycles with the PC held
//   flush_events             perf counter: redirect/halt flush events
//
// Build option:
//   PIPE_HAZARD_CTRL_PERF_CNT_EN  enables the two saturating perf counters;
//                                 when undefined both outputs read 0.

module pipe_hazard_ctrl #(
  parameter int LU_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic [2:0]  ex_write_reg,
  input  logic        ex_RegWrt,
  input  logic        ex_MemRead,
  input  logic        redirect_mem,
  input  logic        halt_mem,
  input  logic        imem_stall,
  input  logic        dmem_stall,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        halted,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events
);

  typedef enum logic [1:0] {RUN, LU_STALL, HALT_DRAIN, HALTED} state_t;

  // Bubbles still owed after the first one, loaded on entry to LU_STALL.
  localparam logic [1:0] LU_EXTRA = 2'(LU_BUBBLES - 1);

  state_t     state_q, state_d;
  logic [1:0] bub_q, bub_d;
  logic       load_use;

  logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
  logic ifid_fl_c, idex_fl_c, exmem_fl_c, memwb_fl_c;

  // R0 is a real register here, so there is no zero-register exclusion.
  assign load_use = ex_MemRead & ex_RegWrt &
                    ((id_rs_used & (id_rs == ex_write_reg)) |
                     (id_rt_used & (id_rt == ex_write_reg)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      bub_q   <= 2'd0;
      halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      halted  <= (state_d == HALTED);
    end
  end

  always_comb begin
    state_d    = state_q;
    bub_d      = bub_q;
    pc_en_c    = 1'b1;
    ifid_en_c  = 1'b1;
    idex_en_c  = 1'b1;
    exmem_en_c = 1'b1;
    memwb_en_c = 1'b1;
    ifid_fl_c  = 1'b0;
    idex_fl_c  = 1'b0;
    exmem_fl_c = 1'b0;
    memwb_fl_c = 1'b0;

    if (state_q == HALTED) begin
      pc_en_c    = 1'b0;
      ifid_en_c  = 1'b0;
      idex_en_c  = 1'b0;
      exmem_en_c = 1'b0;
      memwb_en_c = 1'b0;
    end else if (dmem_stall) begin
      // Whole pipe frozen; WB gets a bubble so the stalled access does not
      // retire twice. FSM state and bubble count hold.
      pc_en_c    = 1'b0;
      ifid_en_c  = 1'b0;
      idex_en_c  = 1'b0;
      exmem_en_c = 1'b0;
      memwb_en_c = 1'b0;
      memwb_fl_c = 1'b1;
    end else if (state_q == HALT_DRAIN) begin
      pc_en_c    = 1'b0;
      ifid_fl_c  = 1'b1;
      idex_fl_c  = 1'b1;
      exmem_fl_c = 1'b1;
      state_d    = HALTED;
    end else if (redirect_mem) begin
      // Also wins over imem_stall: the pending fetch is abandoned.
      ifid_fl_c  = 1'b1;
      idex_fl_c  = 1'b1;
      exmem_fl_c = 1'b1;
      state_d    = RUN;
      bub_d      = 2'd0;
    end else if (halt_mem) begin
      pc_en_c    = 1'b0;
      ifid_fl_c  = 1'b1;
      idex_fl_c  = 1'b1;
      exmem_fl_c = 1'b1;
      state_d    = HALT_DRAIN;
      bub_d      = 2'd0;
    end else if (load_use || state_q == LU_STALL) begin
      pc_en_c   = 1'b0;
      ifid_en_c = 1'b0;
      idex_fl_c = 1'b1;
      if (state_q == LU_STALL) begin
        if (bub_q <= 2'd1) begin
          state_d = RUN;
          bub_d   = 2'd0;
        end else begin
          bub_d = bub_q - 2'd1;
        end
      end else if (LU_BUBBLES > 1) begin
        state_d = LU_STALL;
        bub_d   = LU_EXTRA;
      end
    end else if (imem_stall) begin
      pc_en_c   = 1'b0;
      ifid_fl_c = 1'b1;
    end
  end

  // Everything is held inactive while reset is asserted.
  assign pc_en       = rst & pc_en_c;
  assign ifid_en     = rst & ifid_en_c;
  assign idex_en     = rst & idex_en_c;
  assign exmem_en    = rst & exmem_en_c;
  assign memwb_en    = rst & memwb_en_c;
  assign ifid_flush  = rst & ifid_fl_c;
  assign idex_flush  = rst & idex_fl_c;
  assign exmem_flush = rst & exmem_fl_c;
  assign memwb_flush = rst & memwb_fl_c;

`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_q, flush_q;
  logic        flush_evt;

  // One event per redirect or halt taken from MEM (the drain cycle is part
  // of the same halt event).
  assign flush_evt = ((state_q == RUN) || (state_q == LU_STALL)) &
                     ~dmem_stall & (redirect_mem | halt_mem);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else if (state_q != HALTED) begin
      if (!pc_en_c) stall_q <= sat_inc(stall_q);
      if (flush_evt) flush_q <= sat_inc(flush_q);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = 16'd0;
  assign flush_events = 16'd0;
`endif

endmodule
